// File: rtl/alu_pkg.sv
// Shared opcode definitions for the ALU arbiter and its datapath.
package alu_pkg;

  localparam int unsigned OpWidth   = 2;
  localparam int unsigned FifoDepth = 2;

  typedef enum logic [OpWidth-1:0] {
    OpAdd = 2'd0,
    OpSub = 2'd1,
    OpAnd = 2'd2,
    OpOr  = 2'd3
  } alu_op_e;

endpackage

// File: rtl/proto_alu.sv
// Single-cycle registered ALU: an operation presented in cycle N has its result valid in N+1.
module proto_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [OpWidth-1:0] op_i,
  output logic               out_valid_o,
  output logic [WIDTH-1:0]   result_o
);

  logic [WIDTH-1:0] result_d, result_q;
  logic             valid_q;

  // ADD/SUB wrap naturally at WIDTH bits.
  always_comb begin
    result_d = '0;
    unique case (alu_op_e'(op_i))
      OpAdd: result_d = a_i + b_i;
      OpSub: result_d = a_i - b_i;
      OpAnd: result_d = a_i & b_i;
      OpOr:  result_d = a_i | b_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      valid_q <= in_valid_i;
      if (in_valid_i) begin
        result_q <= result_d;
      end
    end
  end

  assign out_valid_o = valid_q;
  assign result_o    = result_q;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one proto_alu among NREQ requesters, with an in-order
// 2-entry response FIFO and a credit limit of two outstanding operations.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned NREQ  = 4,
  localparam int unsigned IdW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_operandA,
  input  logic [NREQ*WIDTH-1:0]   req_operandB,
  input  logic [NREQ*OpWidth-1:0] req_opcode,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WIDTH-1:0]        rsp_result,
  output logic [IdW-1:0]          rsp_id
);

  logic [WIDTH-1:0]   opa [NREQ];
  logic [WIDTH-1:0]   opb [NREQ];
  logic [OpWidth-1:0] opc [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign opa[i] = req_operandA[i*WIDTH +: WIDTH];
    assign opb[i] = req_operandB[i*WIDTH +: WIDTH];
    assign opc[i] = req_opcode[i*OpWidth +: OpWidth];
  end

  logic [IdW-1:0] ptr_q, ptr_d, grant_idx, tag_q;
  logic           grant_found, credit_ok, handshake;
  int             cand;

  logic             alu_valid;
  logic [WIDTH-1:0] alu_result;

  logic [WIDTH-1:0] fifo_res_q [FifoDepth];
  logic [IdW-1:0]   fifo_id_q  [FifoDepth];
  logic             wr_q, rd_q;
  logic [1:0]       count_q;
  logic             push, pop;

  // First valid port at or above ptr, wrapping modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < int'(NREQ); k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= int'(NREQ)) begin
        cand = cand - int'(NREQ);
      end
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IdW'(cand);
      end
    end
  end

  // The ALU stage (0/1) plus buffered responses (0..2) may never exceed FIFO capacity.
  assign credit_ok = (({1'b0, alu_valid} + count_q) < 2'd2);
  assign handshake = grant_found && credit_ok && !reset;
  assign req_ready = handshake ? (NREQ'(1) << grant_idx) : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (handshake) begin
      ptr_d = (grant_idx == IdW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      tag_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (handshake) begin
        tag_q <= grant_idx;
      end
    end
  end

  proto_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .clk        (clk),
    .reset      (reset),
    .in_valid_i (handshake),
    .a_i        (opa[grant_idx]),
    .b_i        (opb[grant_idx]),
    .op_i       (opc[grant_idx]),
    .out_valid_o(alu_valid),
    .result_o   (alu_result)
  );

  assign push = alu_valid;
  assign pop  = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= 2'd0;
      for (int i = 0; i < int'(FifoDepth); i++) begin
        fifo_res_q[i] <= '0;
        fifo_id_q[i]  <= '0;
      end
    end else begin
      if (push) begin
        fifo_res_q[wr_q] <= alu_result;
        fifo_id_q[wr_q]  <= tag_q;
        wr_q             <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      if (push && !pop) begin
        count_q <= count_q + 2'd1;
      end else if (!push && pop) begin
        count_q <= count_q - 2'd1;
      end
    end
  end

  assign rsp_valid  = !reset && (count_q != 2'd0);
  assign rsp_result = rsp_valid ? fifo_res_q[rd_q] : '0;
  assign rsp_id     = rsp_valid ? fifo_id_q[rd_q] : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a transaction-level model checked every cycle, plus directed literals.
module tb_alu_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] opA, opB;
  logic [N*2-1:0] opc;
  logic           rsp_valid, rsp_ready;
  logic [W-1:0]   rsp_result;
  logic [IW-1:0]  rsp_id;

  always #5 clk = ~clk;

  alu_arbiter #(
    .WIDTH(W),
    .NREQ (N)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_operandA(opA),
    .req_operandB(opB),
    .req_opcode  (opc),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_id      (rsp_id)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [W-1:0] res;
    int           id;
    int           avail;
  } exp_t;

  exp_t exp_q[$];
  int   mptr        = 0;
  int   outstanding = 0;
  int   grant_log[$];

  function automatic logic [W-1:0] ref_alu(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: grant = first valid from model pointer while fewer than two ops are unreturned;
  // each accepted op becomes visible two cycles later and leaves in issue order.
  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    logic         exp_rv;
    int           g;
    cyc++;
    exp_ready = '0;
    g         = -1;
    if (!reset && outstanding < 2) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && req_valid[(mptr + k) % N]) g = (mptr + k) % N;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    exp_rv = !reset && exp_q.size() > 0 && exp_q[0].avail <= cyc;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (exp_rv) begin
      chk("rsp_result", 32'(rsp_result), 32'(exp_q[0].res));
      chk("rsp_id", 32'(rsp_id), exp_q[0].id);
    end
    for (int k = 0; k < N; k++) begin
      if (req_valid[k] && req_ready[k]) grant_log.push_back(k);
    end
    if (reset) begin
      exp_q.delete();
      mptr        = 0;
      outstanding = 0;
    end else begin
      if (exp_rv && rsp_ready) begin
        void'(exp_q.pop_front());
        outstanding--;
      end
      if (g >= 0) begin
        exp_q.push_back('{ref_alu(opc[g*2 +: 2], opA[g*W +: W], opB[g*W +: W]), g, cyc + 2});
        outstanding++;
        mptr = (g + 1) % N;
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b1;
    req_valid = '0;
    repeat (n) next();
    reset = 1'b0;
  endtask

  // Lone request from idle: granted at once, response exactly two cycles later.
  task automatic issue_one(input int port, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] op, input logic [W-1:0] exp_res,
                           input string name);
    opA[port*W +: W] = a;
    opB[port*W +: W] = b;
    opc[port*2 +: 2] = op;
    req_valid        = '0;
    req_valid[port]  = 1'b1;
    @(negedge clk);
    chk({name, "_grant"}, 32'(req_ready), 32'(1) << port);
    next();
    req_valid = '0;
    @(negedge clk);
    chk({name, "_lat1"}, 32'(rsp_valid), 0);
    @(posedge clk);
    @(negedge clk);
    chk({name, "_valid"}, 32'(rsp_valid), 1);
    chk({name, "_result"}, 32'(rsp_result), 32'(exp_res));
    chk({name, "_id"}, 32'(rsp_id), port);
    next();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = '1;
    opA       = '0;
    opB       = '0;
    opc       = '0;
    rsp_ready = 1'b1;
    next();
    next();
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_result", 32'(rsp_result), 0);
    chk("rst_id", 32'(rsp_id), 0);
    next();
    reset     = 1'b0;
    req_valid = '0;

    // First cycle after reset: immediate grant.
    issue_one(2, 8'h05, 8'h03, 2'd0, 8'h08, "single");
    issue_one(0, 8'h00, 8'h01, 2'd1, 8'hFF, "sub_wrap");
    issue_one(0, 8'hFF, 8'h01, 2'd0, 8'h00, "add_wrap");

    // Fairness with all ports requesting.
    do_reset(2);
    grant_log.delete();
    opA       = 32'h44332211;
    opB       = 32'h0F0A0102;
    opc       = 8'b11100100;
    req_valid = '1;
    repeat (16) next();
    req_valid = '0;
    chk("fair_count", 32'(grant_log.size() >= 8), 1);
    for (int k = 0; k < 8 && k < grant_log.size(); k++) begin
      chk("fair_order", grant_log[k], k % 4);
    end
    repeat (4) next();

    // Backpressure: only two ops fit.
    do_reset(2);
    grant_log.delete();
    rsp_ready     = 1'b0;
    opA[1*W +: W] = 8'hF0;
    opB[1*W +: W] = 8'h3C;
    opc[1*2 +: 2] = 2'd2;
    opA[3*W +: W] = 8'h0F;
    opB[3*W +: W] = 8'h30;
    opc[3*2 +: 2] = 2'd3;
    req_valid     = 4'b1010;
    repeat (6) next();
    @(negedge clk);
    chk("bp_accepted", grant_log.size(), 2);
    chk("bp_ready_low", 32'(req_ready), 0);
    next();
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_first_valid", 32'(rsp_valid), 1);
    chk("bp_first_id", 32'(rsp_id), 1);
    chk("bp_first_and", 32'(rsp_result), 32'h30);
    next();
    @(negedge clk);
    chk("bp_second_valid", 32'(rsp_valid), 1);
    chk("bp_second_id", 32'(rsp_id), 3);
    chk("bp_second_or", 32'(rsp_result), 32'h3F);
    next();
    @(negedge clk);
    chk("bp_empty", 32'(rsp_valid), 0);

    // Reset one cycle after a handshake discards the operation.
    next();
    opA[2*W +: W] = 8'h11;
    opB[2*W +: W] = 8'h22;
    req_valid     = 4'b0100;
    @(negedge clk);
    chk("rf_grant", 32'(req_ready), 32'h4);
    next();
    req_valid = '0;
    reset     = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rf_valid_in_reset", 32'(rsp_valid), 0);
      next();
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rf_valid_after", 32'(rsp_valid), 0);
      next();
    end
    req_valid = '1;
    @(negedge clk);
    chk("rf_ptr_zero", 32'(req_ready), 32'h1);
    next();
    req_valid = '0;
    repeat (4) next();

    // Random soak against the model.
    repeat (400) begin
      reset     = ($urandom_range(0, 99) == 0);
      req_valid = N'($urandom_range(0, 15));
      opA       = $urandom;
      opB       = $urandom;
      opc       = 8'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      next();
    end
    reset     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (6) next();
    @(negedge clk);
    chk("soak_drained", 32'(rsp_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits.
REQ-002 Parameter NREQ, default 4: number of requester ports, 2..8.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester operation-request flag.
REQ-006 req_ready  output  NREQ  per-requester accept; handshake when req_valid[i] and req_ready[i] are both high.
REQ-007 req_operandA  input  NREQ x WIDTH  per-requester operand A.
REQ-008 req_operandB  input  NREQ x WIDTH  per-requester operand B.
REQ-009 req_opcode  input  NREQ x 2  per-requester opcode: 0 ADD, 1 SUB, 2 AND, 3 OR.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  response consumer accept; pop when rsp_valid and rsp_ready are both high.
REQ-012 rsp_result  output  WIDTH  ALU result of the response at head.
REQ-013 rsp_id  output  clog2(NREQ)  index of the requester that issued the head response.

Function
REQ-014 At most one req_ready bit SHALL be high per cycle; req_ready SHALL NOT depend on req_valid of a non-granted port.
REQ-015 Grant SHALL be round-robin: search from pointer ptr upward modulo NREQ and grant the first port with req_valid high.
REQ-016 After a handshake on port i, ptr SHALL become (i+1) mod NREQ; without a handshake, ptr SHALL hold.
REQ-017 Grant SHALL be allowed only when the number of in-flight operations (0/1) plus the output FIFO occupancy (0..2) is less than 2; otherwise all req_ready bits SHALL be low.
REQ-018 On a handshake in cycle N, the ALU request SHALL be asserted in cycle N with the granted port's operands and opcode, and the port index SHALL be captured in a tag register.
REQ-019 The ALU result valid in cycle N+1 SHALL be written, with its tag, into a 2-entry response FIFO at the end of cycle N+1.
REQ-020 rsp_valid SHALL be high whenever the FIFO is non-empty; rsp_result and rsp_id SHALL present the head entry and hold stable until popped.
REQ-021 Minimum latency, handshake to rsp_valid: 2 cycles (rsp_valid first high in cycle N+2).
REQ-022 A simultaneous FIFO push and pop SHALL leave occupancy unchanged and preserve order.
REQ-023 Responses SHALL be returned in issue order; no operation SHALL be dropped or duplicated under any rsp_ready pattern.
REQ-024 With rsp_ready held high and all ports requesting, throughput SHALL be one operation per 2 cycles minimum; the credit rule in REQ-017 SHALL never be exceeded.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH; ADD and SUB wrap with no carry or borrow output.

Reset
REQ-026 While reset is high: req_ready = 0, rsp_valid = 0, rsp_result = 0, rsp_id = 0, ptr = 0, FIFO empty, in-flight cleared.
REQ-027 Reset asserted mid-operation SHALL discard any in-flight and buffered responses; none SHALL appear after reset deasserts.
REQ-028 The first grant SHALL be possible in the first cycle after reset deasserts.

Structure
REQ-029 Shared package alu_pkg SHALL hold the opcode enum (ADD/SUB/AND/OR = 0..3) and the opcode width constant.
REQ-030 The block SHALL instantiate one proto_alu as its only sub-module; the arbiter, tag register and FIFO SHALL be inline.

Verification
REQ-031 Single request: port 2, A=0x05, B=0x03, op ADD, rsp_ready=1 -> rsp_valid 2 cycles later, result 0x08, id 2.
REQ-032 Wrap: port 0, SUB, A=0x00, B=0x01 -> result 0xFF. Separately, port 0, ADD, A=0xFF, B=0x01 -> result 0x00.
REQ-033 Fairness: all 4 ports valid continuously -> grant order 0,1,2,3,0,...; no port waits more than NREQ grants.
REQ-034 Backpressure: rsp_ready=0 with ports 1 and 3 requesting -> exactly 2 ops accepted, then req_ready stays 0; release rsp_ready -> ids 1 then 3 in order, correct AND/OR results.
REQ-035 Reset mid-flight: assert reset one cycle after a handshake -> rsp_valid stays 0 through reset and afterward; ptr = 0.
REQ-036 Random soak with a scoreboard against a reference model: in-order, lossless, correct results under random req_valid and rsp_ready.
